// File: rtl/move_executor.sv
// move_executor: applies moves chosen by the decision FSM to the ball position
// and the per-node edge memory, enforces the field rules, decides who moves
// next (bounce rule) and flags goals / game over.
// Optional feature macro: MOVE_EXEC_BOUNCE_EN (bounce rule enabled when defined;
// otherwise colour alternates on every legal move).
// Handshake: i_direction_valid is a one-cycle strobe accepted only in IDLE;
// strobes in any other state are dropped. Memory reads return data one cycle
// after o_mem_rd_en; writes take effect on the clock edge with o_mem_wr_en.
module move_executor #(
  parameter int FIELD_W  = 8,
  parameter int FIELD_L  = 10,
  parameter bit AI_COLOR = 1'b1,
  parameter int ADDR_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_direction_valid,
  input  logic [2:0]        i_direction,
  output logic [7:0]        o_current_x,
  output logic [7:0]        o_current_y,
  output logic [7:0]        o_width,
  output logic [7:0]        o_length,
  output logic              o_color,
  output logic              o_my_turn,
  output logic              o_busy,
  output logic              o_move_done,
  output logic              o_illegal,
  output logic              o_game_over,
  output logic              o_winner,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  input  logic [7:0]        i_mem_rd_data,
  output logic              o_mem_wr_en,
  output logic [7:0]        o_mem_wr_data,
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [3:0] {
    S_CLEAR   = 4'd0,
    S_IDLE    = 4'd1,
    S_RD_SRC  = 4'd2,
    S_CHK_SRC = 4'd3,
    S_WR_SRC  = 4'd4,
    S_RD_DST  = 4'd5,
    S_WR_DST  = 4'd6,
    S_TURN    = 4'd7,
    S_OVER    = 4'd8
  } state_t;

  localparam int NODES = (FIELD_W + 1) * (FIELD_L + 1);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NODES - 1);
  localparam logic [ADDR_W-1:0] C_STRIDE    = ADDR_W'(FIELD_W + 1);
  localparam logic signed [8:0] C_ZERO = 9'sd0;
  localparam logic signed [8:0] C_W    = 9'(FIELD_W);
  localparam logic signed [8:0] C_L    = 9'(FIELD_L);
  localparam logic signed [8:0] C_MLO  = 9'(FIELD_W / 2 - 1);
  localparam logic signed [8:0] C_MHI  = 9'(FIELD_W / 2 + 1);

`ifdef MOVE_EXEC_BOUNCE_EN
  localparam bit C_BOUNCE = 1'b1;
`else
  localparam bit C_BOUNCE = 1'b0;
`endif

  state_t            r_state, w_next;
  logic [7:0]        r_x, r_y;
  logic              r_color;
  logic [2:0]        r_dir;
  logic [7:0]        r_src_mask;
  logic              r_revisit;
  logic              r_legal;
  logic              r_game_over;
  logic              r_winner;
  logic [ADDR_W-1:0] r_clr_addr;

  logic signed [8:0] w_dx, w_dy;
  logic signed [8:0] w_src_x, w_src_y, w_dst_x, w_dst_y;
  logic [7:0]        w_dir_bit, w_opp_bit;
  logic              w_x_out, w_y_out, w_in_mouth, w_same_border, w_dst_border;
  logic              w_illegal, w_goal, w_next_color;
  logic [ADDR_W-1:0] w_src_addr, w_dst_addr;
  logic              w_rd_en, w_wr_en, w_illegal_p, w_move_done_p, w_my_turn_p;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wr_data;

  function automatic logic [ADDR_W-1:0] node_addr(input logic [7:0] x, input logic [7:0] y);
    node_addr = ADDR_W'(y) * C_STRIDE + ADDR_W'(x);
  endfunction

  // Direction code to (dx,dy) step.
  always_comb begin
    w_dx = C_ZERO;
    w_dy = C_ZERO;
    case (r_dir)
      3'd0: begin w_dx =  9'sd0; w_dy =  9'sd1; end
      3'd1: begin w_dx =  9'sd1; w_dy =  9'sd1; end
      3'd2: begin w_dx =  9'sd1; w_dy =  9'sd0; end
      3'd3: begin w_dx =  9'sd1; w_dy = -9'sd1; end
      3'd4: begin w_dx =  9'sd0; w_dy = -9'sd1; end
      3'd5: begin w_dx = -9'sd1; w_dy = -9'sd1; end
      3'd6: begin w_dx = -9'sd1; w_dy =  9'sd0; end
      default: begin w_dx = -9'sd1; w_dy = 9'sd1; end
    endcase
  end

  // Destination geometry and rule evaluation for the latched move.
  always_comb begin
    w_src_x       = signed'({1'b0, r_x});
    w_src_y       = signed'({1'b0, r_y});
    w_dst_x       = w_src_x + w_dx;
    w_dst_y       = w_src_y + w_dy;
    w_dir_bit     = 8'd1 << r_dir;
    w_opp_bit     = 8'd1 << (r_dir + 3'd4);
    w_x_out       = (w_dst_x < C_ZERO) || (w_dst_x > C_W);
    w_y_out       = (w_dst_y < C_ZERO) || (w_dst_y > C_L);
    w_in_mouth    = (w_dst_x >= C_MLO) && (w_dst_x <= C_MHI);
    w_same_border = ((w_src_x == C_ZERO) && (w_dst_x == C_ZERO)) ||
                    ((w_src_x == C_W)    && (w_dst_x == C_W))    ||
                    ((w_src_y == C_ZERO) && (w_dst_y == C_ZERO)) ||
                    ((w_src_y == C_L)    && (w_dst_y == C_L));
    w_dst_border  = (w_dst_x == C_ZERO) || (w_dst_x == C_W) ||
                    (w_dst_y == C_ZERO) || (w_dst_y == C_L);
    w_illegal     = i_mem_rd_data[r_dir] || w_x_out ||
                    (w_y_out && !w_in_mouth) || w_same_border;
    w_goal        = !w_illegal && w_y_out;
    w_src_addr    = node_addr(r_x, r_y);
    w_dst_addr    = node_addr(w_dst_x[7:0], w_dst_y[7:0]);
    w_next_color  = (r_legal && !r_revisit) ? ~r_color : r_color;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_next        = r_state;
    w_addr        = '0;
    w_rd_en       = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_data     = 8'd0;
    w_illegal_p   = 1'b0;
    w_move_done_p = 1'b0;
    w_my_turn_p   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_wr_en = 1'b1;
        w_addr  = r_clr_addr;
        if (r_clr_addr == C_LAST_ADDR) w_next = S_TURN;
      end
      S_IDLE: begin
        if (i_direction_valid) w_next = S_RD_SRC;
      end
      S_RD_SRC: begin
        w_rd_en = 1'b1;
        w_addr  = w_src_addr;
        w_next  = S_CHK_SRC;
      end
      S_CHK_SRC: begin
        if (w_illegal) begin
          w_illegal_p = 1'b1;
          w_next      = S_TURN;
        end else if (w_goal) begin
          w_next = S_OVER;
        end else begin
          w_next = S_WR_SRC;
        end
      end
      S_WR_SRC: begin
        w_wr_en   = 1'b1;
        w_addr    = w_src_addr;
        w_wr_data = r_src_mask | w_dir_bit;
        w_next    = S_RD_DST;
      end
      S_RD_DST: begin
        w_rd_en = 1'b1;
        w_addr  = w_dst_addr;
        w_next  = S_WR_DST;
      end
      S_WR_DST: begin
        w_wr_en       = 1'b1;
        w_addr        = w_dst_addr;
        w_wr_data     = i_mem_rd_data | w_opp_bit;
        w_move_done_p = 1'b1;
        w_next        = S_TURN;
      end
      S_TURN: begin
        w_my_turn_p = (w_next_color == AI_COLOR);
        w_next      = S_IDLE;
      end
      S_OVER: w_next = S_OVER;
      default: w_next = S_CLEAR;
    endcase
  end

  // State, position, colour and bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_CLEAR;
      r_x         <= 8'(FIELD_W / 2);
      r_y         <= 8'(FIELD_L / 2);
      r_color     <= 1'b1;
      r_dir       <= 3'd0;
      r_src_mask  <= 8'd0;
      r_revisit   <= 1'b0;
      r_legal     <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_clr_addr  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          r_legal    <= 1'b0;
        end
        S_IDLE: if (i_direction_valid) r_dir <= i_direction;
        S_CHK_SRC: begin
          r_src_mask <= i_mem_rd_data;
          r_legal    <= !w_illegal;
          if (w_goal) begin
            r_game_over <= 1'b1;
            // Beyond the far end is blue's goal; beyond y=0 is red's.
            r_winner    <= (w_dst_y > C_L) ? 1'b0 : 1'b1;
          end
        end
        S_WR_DST: begin
          r_x       <= w_dst_x[7:0];
          r_y       <= w_dst_y[7:0];
          r_revisit <= C_BOUNCE && ((i_mem_rd_data != 8'd0) || w_dst_border);
        end
        S_TURN: r_color <= w_next_color;
        default: ;
      endcase
    end
  end

  // Strobes are masked while reset is held so an interrupted write never lands.
  always_comb begin
    o_mem_addr    = w_addr;
    o_mem_rd_en   = w_rd_en & ~i_rst;
    o_mem_wr_en   = w_wr_en & ~i_rst;
    o_mem_wr_data = w_wr_data;
    o_illegal     = w_illegal_p & ~i_rst;
    o_move_done   = w_move_done_p & ~i_rst;
    o_my_turn     = w_my_turn_p & ~i_rst;
    o_busy        = (r_state != S_IDLE) && (r_state != S_OVER);
    o_current_x   = r_x;
    o_current_y   = r_y;
    o_color       = r_color;
    o_game_over   = r_game_over;
    o_winner      = r_winner;
    o_width       = 8'(FIELD_W);
    o_length      = 8'(FIELD_L);
    o_dbg_state   = r_state;
  end

endmodule
